// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Arbitrates NUM_MASTERS request ports onto a single memory port. One
//   transaction is in flight at a time: the winner is latched in IDLE, the
//   memory request is raised in ISSUE and held through WAIT until mem_ack
//   arrives or the timeout counter expires. Every output is registered.
//
// Parameters
//   NUM_MASTERS  number of requesting masters (2..8)
//   ADDR_W       address width
//   DATA_W       data width
//   ARB_MODE     0 = fixed priority (index 0 highest), 1 = round-robin
//   TIMEOUT      cycles allowed in WAIT before an error pulse (>= 2)
//
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   m_req_valid, m_rd_wr         per-master request and direction (1 = write)
//   m_rd_addr, m_wr_addr         per-master addresses, master i at slice i
//   m_wr_data                    per-master write data, master i at slice i
//   m_rd_data                    captured memory read data, valid with m_ack
//   m_ack, m_err                 one-hot completion / timeout pulses
//   m_sel                        one-hot current grant, zero when idle
//   mem_rd_addr, mem_wr_addr     memory-side addresses
//   mem_wr_data, mem_rd_wr       memory-side write data and direction
//   mem_req_valid                memory request, held until completion
//   mem_rd_data, mem_ack         memory read data and completion
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req_valid,
    input  logic [NUM_MASTERS-1:0]        m_rd_wr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_rd_addr,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_wr_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
    output logic [DATA_W-1:0]             m_rd_data,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic [NUM_MASTERS-1:0]        m_sel,
    output logic [ADDR_W-1:0]             mem_rd_addr,
    output logic [ADDR_W-1:0]             mem_wr_addr,
    output logic [DATA_W-1:0]             mem_wr_data,
    output logic                          mem_rd_wr,
    output logic                          mem_req_valid,
    input  logic [DATA_W-1:0]             mem_rd_data,
    input  logic                          mem_ack
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                   state_reg, state_next;
    logic [NUM_MASTERS-1:0]   m_sel_reg, m_sel_next;
    logic [NUM_MASTERS-1:0]   m_ack_reg, m_ack_next;
    logic [NUM_MASTERS-1:0]   m_err_reg, m_err_next;
    logic [DATA_W-1:0]        m_rd_data_reg, m_rd_data_next;
    logic [ADDR_W-1:0]        mem_rd_addr_reg, mem_rd_addr_next;
    logic [ADDR_W-1:0]        mem_wr_addr_reg, mem_wr_addr_next;
    logic [DATA_W-1:0]        mem_wr_data_reg, mem_wr_data_next;
    logic                     mem_rd_wr_reg, mem_rd_wr_next;
    logic                     mem_req_valid_reg, mem_req_valid_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [IDX_W-1:0]         rr_ptr_reg, rr_ptr_next;

    // Unpacked views of the flattened per-master buses.
    logic [ADDR_W-1:0] rd_addr_arr [NUM_MASTERS];
    logic [ADDR_W-1:0] wr_addr_arr [NUM_MASTERS];
    logic [DATA_W-1:0] wr_data_arr [NUM_MASTERS];

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
        assign rd_addr_arr[gi] = m_rd_addr[gi*ADDR_W +: ADDR_W];
        assign wr_addr_arr[gi] = m_wr_addr[gi*ADDR_W +: ADDR_W];
        assign wr_data_arr[gi] = m_wr_data[gi*DATA_W +: DATA_W];
    end

    // Winner selection. Round-robin scans upward from the slot after the
    // last grant, wrapping at NUM_MASTERS (which need not be a power of 2).
    logic [IDX_W-1:0] win_idx;
    logic             win_found;

    always_comb begin
        int cand;
        win_idx   = '0;
        win_found = 1'b0;
        cand      = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req_valid[IDX_W'(i)]) begin
                    win_idx   = IDX_W'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                cand = int'(rr_ptr_reg) + k;
                if (cand >= NUM_MASTERS) begin
                    cand = cand - NUM_MASTERS;
                end
                if (!win_found && m_req_valid[IDX_W'(cand)]) begin
                    win_idx   = IDX_W'(cand);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next         = state_reg;
        m_sel_next         = m_sel_reg;
        m_ack_next         = '0;
        m_err_next         = '0;
        m_rd_data_next     = m_rd_data_reg;
        mem_rd_addr_next   = mem_rd_addr_reg;
        mem_wr_addr_next   = mem_wr_addr_reg;
        mem_wr_data_next   = mem_wr_data_reg;
        mem_rd_wr_next     = mem_rd_wr_reg;
        mem_req_valid_next = mem_req_valid_reg;
        cnt_next           = cnt_reg;
        rr_ptr_next        = rr_ptr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    m_sel_next       = NUM_MASTERS'(1) << win_idx;
                    mem_rd_addr_next = rd_addr_arr[win_idx];
                    mem_wr_addr_next = wr_addr_arr[win_idx];
                    mem_wr_data_next = wr_data_arr[win_idx];
                    mem_rd_wr_next   = m_rd_wr[win_idx];
                    rr_ptr_next      = win_idx;
                    state_next       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid_next = 1'b1;
                cnt_next           = '0;
                state_next         = ST_WAIT;
            end
            ST_WAIT: begin
                // An ack arriving in the final counted cycle still completes
                // normally, so it is tested before the timeout.
                if (mem_ack) begin
                    m_ack_next         = m_sel_reg;
                    m_rd_data_next     = mem_rd_data;
                    mem_req_valid_next = 1'b0;
                    m_sel_next         = '0;
                    state_next         = ST_IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    m_err_next         = m_sel_reg;
                    mem_req_valid_next = 1'b0;
                    m_sel_next         = '0;
                    state_next         = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_IDLE;
            m_sel_reg         <= '0;
            m_ack_reg         <= '0;
            m_err_reg         <= '0;
            m_rd_data_reg     <= '0;
            mem_rd_addr_reg   <= '0;
            mem_wr_addr_reg   <= '0;
            mem_wr_data_reg   <= '0;
            mem_rd_wr_reg     <= 1'b0;
            mem_req_valid_reg <= 1'b0;
            cnt_reg           <= '0;
            rr_ptr_reg        <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_reg         <= state_next;
            m_sel_reg         <= m_sel_next;
            m_ack_reg         <= m_ack_next;
            m_err_reg         <= m_err_next;
            m_rd_data_reg     <= m_rd_data_next;
            mem_rd_addr_reg   <= mem_rd_addr_next;
            mem_wr_addr_reg   <= mem_wr_addr_next;
            mem_wr_data_reg   <= mem_wr_data_next;
            mem_rd_wr_reg     <= mem_rd_wr_next;
            mem_req_valid_reg <= mem_req_valid_next;
            cnt_reg           <= cnt_next;
            rr_ptr_reg        <= rr_ptr_next;
        end
    end

    assign m_sel         = m_sel_reg;
    assign m_ack         = m_ack_reg;
    assign m_err         = m_err_reg;
    assign m_rd_data     = m_rd_data_reg;
    assign mem_rd_addr   = mem_rd_addr_reg;
    assign mem_wr_addr   = mem_wr_addr_reg;
    assign mem_wr_data   = mem_wr_data_reg;
    assign mem_rd_wr     = mem_rd_wr_reg;
    assign mem_req_valid = mem_req_valid_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Two arbiters (lane 0 fixed priority, lane 1 round-robin) with independent
//   stimulus. A transaction-level model predicts every output from the grant
//   time of each transaction; a negedge process compares DUT against model.
//   Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req   [2];
    logic [N-1:0]    rdwr  [2];
    logic [N*AW-1:0] rda   [2];
    logic [N*AW-1:0] wra   [2];
    logic [N*DW-1:0] wrd   [2];
    logic [DW-1:0]   mrd   [2];
    logic            mack  [2];

    logic [DW-1:0]   o_rdd [2];
    logic [N-1:0]    o_ack [2];
    logic [N-1:0]    o_err [2];
    logic [N-1:0]    o_sel [2];
    logic [AW-1:0]   o_mra [2];
    logic [AW-1:0]   o_mwa [2];
    logic [DW-1:0]   o_mwd [2];
    logic            o_mrw [2];
    logic            o_mrv [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_bus_arbiter #(
            .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(gi), .TIMEOUT(TO)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .m_req_valid  (req[gi]),
            .m_rd_wr      (rdwr[gi]),
            .m_rd_addr    (rda[gi]),
            .m_wr_addr    (wra[gi]),
            .m_wr_data    (wrd[gi]),
            .m_rd_data    (o_rdd[gi]),
            .m_ack        (o_ack[gi]),
            .m_err        (o_err[gi]),
            .m_sel        (o_sel[gi]),
            .mem_rd_addr  (o_mra[gi]),
            .mem_wr_addr  (o_mwa[gi]),
            .mem_wr_data  (o_mwd[gi]),
            .mem_rd_wr    (o_mrw[gi]),
            .mem_req_valid(o_mrv[gi]),
            .mem_rd_data  (mrd[gi]),
            .mem_ack      (mack[gi])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- transaction-level reference model ----------------
    // A transaction granted at edge t_g shows m_sel after t_g, raises
    // mem_req_valid after t_g+1, may complete on any ack sampled from edge
    // t_g+2 on, and times out at edge t_g+TO+1 without one.
    logic [N-1:0]  e_sel [2];
    logic [N-1:0]  e_ack [2];
    logic [N-1:0]  e_err [2];
    logic [DW-1:0] e_rdd [2];
    logic [AW-1:0] e_mra [2];
    logic [AW-1:0] e_mwa [2];
    logic [DW-1:0] e_mwd [2];
    logic          e_mrw [2];
    logic          e_mrv [2];
    bit            busy  [2];
    int            t_g   [2];
    int            ptr   [2];
    int            cyc = 0;

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d]  = 1'b0;
            ptr[d]   = N - 1;
            e_sel[d] = '0;  e_ack[d] = '0;  e_err[d] = '0;  e_rdd[d] = '0;
            e_mra[d] = '0;  e_mwa[d] = '0;  e_mwd[d] = '0;
            e_mrw[d] = 1'b0; e_mrv[d] = 1'b0;
        end
    endfunction

    function automatic int pick(int d);
        if (d == 0) begin
            for (int i = 0; i < N; i++) if (req[d][i]) return i;
        end else begin
            for (int k = 1; k <= N; k++) if (req[d][(ptr[d] + k) % N]) return (ptr[d] + k) % N;
        end
        return 0;
    endfunction

    function automatic void finish_txn(int d);
        busy[d]  = 1'b0;
        e_mrv[d] = 1'b0;
        e_sel[d] = '0;
    endfunction

    function automatic void model_step();
        int w;
        if (!reset) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_ack[d] = '0;
                e_err[d] = '0;
                if (!busy[d]) begin
                    if (req[d] != '0) begin
                        w        = pick(d);
                        busy[d]  = 1'b1;
                        t_g[d]   = cyc;
                        ptr[d]   = w;
                        e_sel[d] = N'(1) << w;
                        e_mra[d] = rda[d][w*AW +: AW];
                        e_mwa[d] = wra[d][w*AW +: AW];
                        e_mwd[d] = wrd[d][w*DW +: DW];
                        e_mrw[d] = rdwr[d][w];
                    end
                end else if (cyc == t_g[d] + 1) begin
                    e_mrv[d] = 1'b1;
                end else if (mack[d]) begin
                    e_ack[d] = e_sel[d];
                    e_rdd[d] = mrd[d];
                    finish_txn(d);
                end else if (cyc == t_g[d] + TO + 1) begin
                    e_err[d] = e_sel[d];
                    finish_txn(d);
                end
            end
        end
        cyc++;
    endfunction

    // One clock edge: advance the model with the inputs the DUT just sampled.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && reset) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("L%0d_sel", d), 64'(o_sel[d]), 64'(e_sel[d]));
                chk($sformatf("L%0d_ack", d), 64'(o_ack[d]), 64'(e_ack[d]));
                chk($sformatf("L%0d_err", d), 64'(o_err[d]), 64'(e_err[d]));
                chk($sformatf("L%0d_rd_data", d), 64'(o_rdd[d]), 64'(e_rdd[d]));
                chk($sformatf("L%0d_mem_req_valid", d), 64'(o_mrv[d]), 64'(e_mrv[d]));
                chk($sformatf("L%0d_mem_rd_wr", d), 64'(o_mrw[d]), 64'(e_mrw[d]));
                chk($sformatf("L%0d_mem_rd_addr", d), 64'(o_mra[d]), 64'(e_mra[d]));
                chk($sformatf("L%0d_mem_wr_addr", d), 64'(o_mwa[d]), 64'(e_mwa[d]));
                chk($sformatf("L%0d_mem_wr_data", d), 64'(o_mwd[d]), 64'(e_mwd[d]));
                if (o_ack[d] != '0 || o_err[d] != '0)
                    $display("txn lane=%0d ack=%b err=%b rd_data=0x%08h", d, o_ack[d], o_err[d], o_rdd[d]);
            end
        end
    end

    task automatic wait_mrv(int d);
        for (int k = 0; k < 10; k++) begin
            if (o_mrv[d]) return;
            step();
        end
        chk($sformatf("L%0d_wait_mem_req_valid_bound", d), 64'(o_mrv[d]), 64'(1));
    endtask

    task automatic check_all_zero(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_L%0d_ctl", tag, d),
                64'({o_sel[d], o_ack[d], o_err[d], o_mrv[d], o_mrw[d]}), 64'(0));
            chk($sformatf("%s_L%0d_data", tag, d),
                64'(o_rdd[d] | o_mwd[d] | o_mra[d] | o_mwa[d]), 64'(0));
        end
    endtask

    task automatic rand_drive();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (req[d][i] && (o_ack[d][i] || o_err[d][i])) begin
                    req[d][i] = 1'b0;
                end else if (req[d][i] && o_sel[d][i] && $urandom_range(0, 15) == 0) begin
                    req[d][i] = 1'b0;   // master gives up after its grant
                end else if (!req[d][i] && $urandom_range(0, 3) == 0) begin
                    req[d][i]          = 1'b1;
                    rdwr[d][i]         = 1'($urandom_range(0, 1));
                    rda[d][i*AW +: AW] = $urandom();
                    wra[d][i*AW +: AW] = $urandom();
                    wrd[d][i*DW +: DW] = $urandom();
                end
            end
            mack[d] = ($urandom_range(0, 5) == 0);
            mrd[d]  = $urandom();
        end
    endtask

    initial begin
        logic [N-1:0] prev;
        logic [N-1:0] got [5];
        logic [N-1:0] rr_exp [5];
        int ng;
        rr_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

        for (int d = 0; d < 2; d++) begin
            req[d] = '0; rdwr[d] = '0; rda[d] = '0; wra[d] = '0; wrd[d] = '0;
            mrd[d] = '0; mack[d] = 1'b0;
        end
        model_reset();
        step();
        step();
        check_all_zero("reset");
        reset  = 1'b1;
        chk_en = 1'b1;
        step();

        // Round-robin, all masters requesting, memory acks immediately.
        req[1]  = 4'hF;
        mack[1] = 1'b1;
        prev    = '0;
        ng      = 0;
        for (int k = 0; k < 40 && ng < 5; k++) begin
            step();
            if (o_sel[1] != '0 && prev == '0) begin
                got[ng] = o_sel[1];
                ng++;
            end
            prev = o_sel[1];
        end
        chk("rr_grant_count", 64'(ng), 64'(5));
        for (int i = 0; i < 5; i++) chk($sformatf("rr_grant_%0d", i), 64'(got[i]), 64'(rr_exp[i]));
        req[1] = '0;
        repeat (4) step();
        mack[1] = 1'b0;
        step();

        // Fixed priority read: requests 1010, ack in cycle 3.
        req[0] = 4'b1010;
        rdwr[0] = '0;
        step();
        chk("fx_sel_c1", 64'(o_sel[0]), 64'(4'b0010));
        chk("fx_mrv_c1", 64'(o_mrv[0]), 64'(0));
        step();
        chk("fx_mrv_c2", 64'(o_mrv[0]), 64'(1));
        step();
        chk("fx_mrv_c3", 64'(o_mrv[0]), 64'(1));
        mack[0] = 1'b1;
        mrd[0]  = 32'hDEADBEEF;
        step();
        mack[0] = 1'b0;
        req[0]  = '0;
        chk("fx_ack_c4", 64'(o_ack[0]), 64'(4'b0010));
        chk("fx_rdd_c4", 64'(o_rdd[0]), 64'(32'hDEADBEEF));
        chk("fx_mrv_c4", 64'(o_mrv[0]), 64'(0));
        chk("fx_sel_c4", 64'(o_sel[0]), 64'(0));
        step();
        chk("fx_ack_c5", 64'(o_ack[0]), 64'(0));

        // Write from master 2: fields stable until the ack.
        req[0]  = 4'b0100;
        rdwr[0] = 4'b0100;
        wra[0][2*AW +: AW] = 32'h100;
        wrd[0][2*DW +: DW] = 32'h55;
        wait_mrv(0);
        for (int k = 0; k < 5; k++) begin
            chk("wr_rd_wr", 64'(o_mrw[0]), 64'(1));
            chk("wr_addr", 64'(o_mwa[0]), 64'(32'h100));
            chk("wr_data", 64'(o_mwd[0]), 64'(32'h55));
            chk("wr_mrv", 64'(o_mrv[0]), 64'(1));
            step();
        end
        mack[0] = 1'b1;
        step();
        mack[0] = 1'b0;
        req[0]  = '0;
        rdwr[0] = '0;
        chk("wr_ack", 64'(o_ack[0]), 64'(4'b0100));
        step();

        // Timeout: no ack, error exactly 16 cycles after mem_req_valid rises.
        req[0] = 4'b0001;
        wait_mrv(0);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("to_err_early", 64'(o_err[0]), 64'(0));
        end
        step();
        req[0] = '0;
        chk("to_err_c16", 64'(o_err[0]), 64'(4'b0001));
        chk("to_mrv_c16", 64'(o_mrv[0]), 64'(0));
        step();
        chk("to_err_pulse", 64'(o_err[0]), 64'(0));

        // Ack in the last counted WAIT cycle beats the timeout.
        req[0] = 4'b1000;
        wait_mrv(0);
        repeat (15) step();
        mack[0] = 1'b1;
        mrd[0]  = 32'h12345678;
        step();
        mack[0] = 1'b0;
        req[0]  = '0;
        chk("co_ack", 64'(o_ack[0]), 64'(4'b1000));
        chk("co_err", 64'(o_err[0]), 64'(0));
        chk("co_rdd", 64'(o_rdd[0]), 64'(32'h12345678));
        step();

        // Reset in the middle of WAIT on both lanes.
        req[0] = 4'b0001;
        req[1] = 4'b0010;
        wait_mrv(0);
        step();
        step();
        #2 reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        req[0] = '0;
        req[1] = '0;
        step();
        step();
        #2 reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("rst_no_pulse", 64'(o_ack[0] | o_err[0] | o_ack[1] | o_err[1]), 64'(0));
        end
        req[1] = 4'b1001;
        step();
        chk("rst_rr_ptr", 64'(o_sel[1]), 64'(4'b0001));
        mack[1] = 1'b1;
        repeat (3) step();
        mack[1] = 1'b0;
        req[1]  = '0;
        step();

        // Randomized traffic on both lanes against the model.
        for (int k = 0; k < 1200; k++) begin
            rand_drive();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
